intr_ctrl: RTL
==============

INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 8, SHALL set the number of interrupt sources (legal 2..32).
REQ-002 Parameter ID_W, default $clog2(NUM_SRC), SHALL set the width of INT_ID.
REQ-003 CLK  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 RST_N  in  1  reset, asynchronous, active-low.
REQ-005 INT_SRC  in  NUM_SRC  interrupt source lines; a rising edge requests service.
REQ-006 I_SET  in  1  global interrupt enable set (SEI / RETIE).
REQ-007 I_CLR  in  1  global interrupt enable clear (CLI).
REQ-008 MASK_WE  in  1  mask register write strobe.
REQ-009 MASK_DIN  in  NUM_SRC  mask write data; 1 = source enabled.
REQ-010 INT_ACK  in  1  CPU accepts the current request.
REQ-011 INT_REQ  out  1  interrupt request to CPU.
REQ-012 INT_ID  out  ID_W  index of the requested source, valid while INT_REQ=1.
REQ-013 INT_EN  out  1  global enable flag.
REQ-014 PENDING  out  NUM_SRC  pending flags.
REQ-015 MASK  out  NUM_SRC  current mask register.

Function
REQ-016 Edge detect: PENDING[i] SHALL set at the first CLK edge where INT_SRC[i]=1 and its registered previous sample is 0; levels held high SHALL NOT re-set it.
REQ-017 INT_EN: I_CLR=1 -> 0; else I_SET=1 -> 1; else hold; I_CLR SHALL win when both are asserted.
REQ-018 MASK SHALL load MASK_DIN on an edge with MASK_WE=1; PENDING SHALL set regardless of mask.
REQ-019 Priority: lowest index among (PENDING & MASK) SHALL win.
REQ-020 FSM states IDLE, REQ, SERVICE; INT_REQ=1 only in REQ (Moore, registered).
REQ-021 IDLE->REQ when INT_EN=1 and |(PENDING & MASK); winning index latched into INT_ID on that edge.
REQ-022 INT_ID SHALL stay stable throughout REQ; later higher-priority arrivals SHALL NOT preempt.
REQ-023 REQ->SERVICE on INT_ACK=1: PENDING[INT_ID] cleared and INT_EN cleared on the same edge.
REQ-024 REQ->IDLE, without ACK, if INT_EN=0 or MASK[INT_ID]=0 (including same-edge I_CLR or mask write); PENDING retained.
REQ-025 SERVICE->IDLE on the edge where INT_EN becomes 1.
REQ-026 If a new rising edge on source INT_ID coincides with ACK, PENDING[INT_ID] SHALL remain 1 (set wins over clear).
REQ-027 INT_ACK outside REQ SHALL be ignored.
REQ-028 Latency: source edge sampled at edge k -> PENDING at k, INT_REQ high after k+1 (INT_EN=1, unmasked).

Reset
REQ-029 RST_N=0 SHALL immediately force: PENDING=0, MASK=0, INT_EN=0, edge-history=0, FSM=IDLE, INT_REQ=0, INT_ID=0.
REQ-030 Reset mid-REQ or mid-SERVICE SHALL abandon the request with no pending retained.
REQ-031 Sources already high at reset release SHALL NOT generate a request (history reset to 0 is replaced by sampling: first post-reset edge loads history only, no PENDING set).

Configuration
REQ-032 Macro INTR_SYNC_EN defined: each INT_SRC bit SHALL pass a two-flop synchroniser (reset 0) before edge detect, adding 2 cycles to REQ-028 latency.
REQ-033 INTR_SYNC_EN undefined: INT_SRC SHALL feed edge detect directly; sources must be CLK-synchronous.

Verification
REQ-034 Reset, MASK=0xFF, I_SET, pulse INT_SRC[3] -> PENDING=0x08, INT_REQ=1 with INT_ID=3 one cycle later.
REQ-035 INT_SRC=0x24 same cycle, enabled -> INT_ID=2; ACK -> PENDING=0x20, INT_EN=0; I_SET -> INT_ID=5 request.
REQ-036 MASK=0xFE, pulse INT_SRC[0] -> PENDING=0x01, INT_REQ stays 0; write MASK=0xFF -> INT_REQ=1, INT_ID=0.
REQ-037 In REQ assert I_SET and I_CLR together -> INT_EN=0, FSM IDLE, INT_REQ=0, PENDING unchanged.
REQ-038 New edge on INT_SRC[INT_ID] coincident with ACK -> PENDING bit stays 1; second request after I_SET.
REQ-039 Drop RST_N mid-REQ (no clock) -> INT_REQ=0, PENDING=0 immediately; rerun REQ-034 with INTR_SYNC_EN -> INT_REQ 2 cycles later.

Source files
------------

// File: rtl/intr_ctrl.sv
// Edge-triggered, maskable interrupt controller with a fixed lowest-index-wins priority.
// Optional INT_SRC input synchroniser, enabled by defining INTR_SYNC_EN.
module intr_ctrl #(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [NUM_SRC-1:0] INT_SRC,
    input  logic               I_SET,
    input  logic               I_CLR,
    input  logic               MASK_WE,
    input  logic [NUM_SRC-1:0] MASK_DIN,
    input  logic               INT_ACK,
    output logic               INT_REQ,
    output logic [ID_W-1:0]    INT_ID,
    output logic               INT_EN,
    output logic [NUM_SRC-1:0] PENDING,
    output logic [NUM_SRC-1:0] MASK
);

    // state   | meaning
    // IDLE    | no request outstanding, waiting for an enabled and unmasked pending source
    // REQ     | INT_REQ high, INT_ID frozen until the CPU acks or the request is withdrawn
    // SERVICE | handler running, global enable off, waiting for the enable to be set again
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERVICE} state_t;

`ifdef INTR_SYNC_EN
    localparam int SYNC_LAT = 2;
    logic [NUM_SRC-1:0] sync_1, sync_2;
    logic [NUM_SRC-1:0] src_in;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= INT_SRC;
            sync_2 <= sync_1;
        end
    end
    assign src_in = sync_2;
`else
    localparam int SYNC_LAT = 0;
    logic [NUM_SRC-1:0] src_in;
    assign src_in = INT_SRC;
`endif

    state_t             state;
    logic [NUM_SRC-1:0] src_hist;
    logic [SYNC_LAT:0]  hist_vld;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] ack_clr;
    logic [ID_W-1:0]    win_id;
    logic               ack_take;
    logic               req_abort;

    // History only becomes trustworthy once the input path holds a real post-reset sample,
    // so sources already high at reset release never look like a rising edge.
    assign rise      = hist_vld[SYNC_LAT] ? (src_in & ~src_hist) : '0;
    assign cand      = PENDING & MASK;
    assign ack_take  = (state == ST_REQ) && INT_ACK;
    assign req_abort = I_CLR || !INT_EN || (MASK_WE ? !MASK_DIN[INT_ID] : !MASK[INT_ID]);

    always_comb begin
        win_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (cand[i]) win_id = ID_W'(i);
        end
    end

    always_comb begin
        ack_clr = '0;
        if (ack_take) ack_clr[INT_ID] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            src_hist <= '0;
            hist_vld <= '0;
            PENDING  <= '0;
            MASK     <= '0;
        end else begin
            src_hist <= src_in;
            hist_vld <= (hist_vld << 1) | (SYNC_LAT + 1)'(1);
            // A new edge on the acked source wins over the ack clear.
            PENDING  <= (PENDING & ~ack_clr) | rise;
            if (MASK_WE) MASK <= MASK_DIN;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= ST_IDLE;
            INT_REQ <= 1'b0;
            INT_ID  <= '0;
            INT_EN  <= 1'b0;
        end else begin
            if (I_CLR || ack_take) INT_EN <= 1'b0;
            else if (I_SET)        INT_EN <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (INT_EN && |cand) begin
                        state   <= ST_REQ;
                        INT_REQ <= 1'b1;
                        INT_ID  <= win_id;
                    end
                end
                ST_REQ: begin
                    if (INT_ACK) begin
                        state   <= ST_SERVICE;
                        INT_REQ <= 1'b0;
                    end else if (req_abort) begin
                        state   <= ST_IDLE;
                        INT_REQ <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (I_SET && !I_CLR) state <= ST_IDLE;
                end
                default: begin
                    state   <= ST_IDLE;
                    INT_REQ <= 1'b0;
                end
            endcase
        end
    end

endmodule
